// File: rtl/sd_sector_arbiter_pkg.sv
// rtl/sd_sector_arbiter_pkg.sv - shared types and constants for the SD sector arbiter
package sd_arb_pkg;

    localparam int SD_LBA_W = 32;
    localparam int MAX_NCLI = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } arb_state_t;

    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// rtl/sd_sector_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick #(
    parameter int  N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin : pick
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // scan farthest-first so the requester closest to ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - shares the SD sector command port among NCLI clients
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int  NCLI  = 3,
    parameter int  TMO_W = 24,
    localparam int OW    = $clog2(NCLI)
) (
    input  logic                     clk_bus,
    input  logic                     reset_n,
    input  logic [NCLI-1:0]          cli_req,
    input  logic [NCLI-1:0]          cli_wr,
    input  logic [NCLI-1:0]          cli_conf,
    input  logic [NCLI*SD_LBA_W-1:0] cli_lba,
    output logic [NCLI-1:0]          cli_gnt,
    output logic [NCLI-1:0]          cli_done,
    output logic                     cli_err,
    output logic [OW-1:0]            owner,
    output logic                     busy,
    output logic [SD_LBA_W-1:0]      sd_lba,
    output logic                     sd_rd,
    output logic                     sd_wr,
    output logic                     sd_conf,
    input  logic                     sd_ack
);

    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    arb_state_t          state, state_nxt;
    logic                ack_m, ack_s;
    logic [OW-1:0]       rr_ptr, rr_ptr_nxt, owner_nxt, pick_idx;
    logic                pick_valid;
    logic [NCLI-1:0]     gnt_nxt;
    logic [TMO_W-1:0]    tmo, tmo_nxt;
    logic                err_q, err_nxt;
    logic [SD_LBA_W-1:0] lba_sel, lba_nxt;
    logic                rd_nxt, wr_nxt, conf_nxt;
    logic                done_now;

    rr_pick #(.N(NCLI)) u_pick (
        .req   (cli_req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= sd_ack;
            ack_s <= ack_m;
        end
    end

    always_comb begin
        lba_sel = '0;
        for (int k = 0; k < NCLI; k++)
            if (pick_idx == OW'(k)) lba_sel = cli_lba[SD_LBA_W*k +: SD_LBA_W];
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        gnt_nxt    = cli_gnt;
        tmo_nxt    = tmo;
        err_nxt    = err_q;
        lba_nxt    = sd_lba;
        rd_nxt     = sd_rd;
        wr_nxt     = sd_wr;
        conf_nxt   = sd_conf;
        case (state)
            IDLE: begin
                // a stale ack from the previous transfer must clear before a new command
                if (pick_valid && !ack_s) begin
                    owner_nxt = pick_idx;
                    gnt_nxt   = NCLI'(1) << pick_idx;
                    conf_nxt  = cli_conf[pick_idx];
                    lba_nxt   = cli_conf[pick_idx] ? '0 : lba_sel;
                    rd_nxt    = !cli_wr[pick_idx];
                    wr_nxt    = cli_wr[pick_idx];
                    tmo_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE, XFER: begin
                if (tmo == TMO_LAST) begin
                    tmo_nxt   = '1;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                    if (state == ISSUE && ack_s) begin
                        rd_nxt    = 1'b0;
                        wr_nxt    = 1'b0;
                        state_nxt = XFER;
                    end else if (state == XFER && !ack_s) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!ack_s) begin
                    gnt_nxt    = '0;
                    rr_ptr_nxt = OW'(wrap_inc(int'(owner), NCLI));
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            cli_gnt <= '0;
            tmo     <= '0;
            err_q   <= 1'b0;
            sd_lba  <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            sd_conf <= 1'b0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            owner   <= owner_nxt;
            cli_gnt <= gnt_nxt;
            tmo     <= tmo_nxt;
            err_q   <= err_nxt;
            sd_lba  <= lba_nxt;
            sd_rd   <= rd_nxt;
            sd_wr   <= wr_nxt;
            sd_conf <= conf_nxt;
        end
    end

    // done fires on the DONE cycle that exits, so a timed-out owner hears once, after ack clears
    assign done_now = (state == DONE) && !ack_s;
    assign cli_done = done_now ? cli_gnt : '0;
    assign cli_err  = done_now & err_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - directed scoreboard bench for sd_sector_arbiter
module tb_sd_sector_arbiter;

    logic        clk_bus = 1'b0;
    logic        reset_n;
    logic [2:0]  cli_req, cli_wr, cli_conf;
    logic [95:0] cli_lba;
    logic [2:0]  cli_gnt, cli_done;
    logic        cli_err, busy, sd_rd, sd_wr, sd_conf, sd_ack;
    logic [1:0]  owner;
    logic [31:0] sd_lba;

    logic [2:0]  cli_req_t, cli_gnt_t, cli_done_t;
    logic        cli_err_t, busy_t, sd_rd_t, sd_wr_t, sd_conf_t, sd_ack_t;
    logic [1:0]  owner_t;
    logic [31:0] sd_lba_t;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic [31:0] lba;
        logic        rd;
        logic        wr;
        logic        conf;
        logic        err;
    } exp_t;
    exp_t sb[$];
    logic [2:0] prev_gnt = '0;

    always #5 clk_bus = ~clk_bus;

    sd_sector_arbiter #(.NCLI(3), .TMO_W(8)) u_dut (
        .clk_bus (clk_bus), .reset_n (reset_n),
        .cli_req (cli_req), .cli_wr (cli_wr), .cli_conf (cli_conf), .cli_lba (cli_lba),
        .cli_gnt (cli_gnt), .cli_done (cli_done), .cli_err (cli_err), .owner (owner),
        .busy (busy), .sd_lba (sd_lba), .sd_rd (sd_rd), .sd_wr (sd_wr),
        .sd_conf (sd_conf), .sd_ack (sd_ack)
    );

    sd_sector_arbiter #(.NCLI(3), .TMO_W(4)) u_dut_tmo (
        .clk_bus (clk_bus), .reset_n (reset_n),
        .cli_req (cli_req_t), .cli_wr (cli_wr), .cli_conf (cli_conf), .cli_lba (cli_lba),
        .cli_gnt (cli_gnt_t), .cli_done (cli_done_t), .cli_err (cli_err_t), .owner (owner_t),
        .busy (busy_t), .sd_lba (sd_lba_t), .sd_rd (sd_rd_t), .sd_wr (sd_wr_t),
        .sd_conf (sd_conf_t), .sd_ack (sd_ack_t)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] lba, input logic rd, input logic wr, input logic conf);
        exp_t e;
        e.id = id; e.lba = lba; e.rd = rd; e.wr = wr; e.conf = conf; e.err = 1'b0;
        sb.push_back(e);
    endtask

    // scoreboard: command fields checked at each grant, completion checked at each done
    always @(negedge clk_bus) begin
        exp_t e;
        if (reset_n) begin
            if (cli_gnt != 3'b000 && prev_gnt == 3'b000) begin
                check("sb_grant_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb[0];
                    check("sb_gnt", cli_gnt, 64'(3'b001 << e.id));
                    check("sb_owner", owner, e.id);
                    check("sb_lba", sd_lba, e.lba);
                    check("sb_rd_wr_conf", {sd_rd, sd_wr, sd_conf}, {e.rd, e.wr, e.conf});
                end
            end
            if (cli_done != 3'b000) begin
                check("sb_done_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_done", cli_done, 64'(3'b001 << e.id));
                    check("sb_err", cli_err, e.err);
                end
            end
            if (busy) check("rd_wr_excl", sd_rd & sd_wr, 0);
        end
        prev_gnt = cli_gnt;
    end

    task automatic wait_gnt();
        int n = 0;
        while (cli_gnt == 3'b000 && n < 50) begin @(negedge clk_bus); n++; end
        check("wait_gnt", 64'(cli_gnt != 3'b000), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (cli_done == 3'b000 && n < 400) begin @(negedge clk_bus); n++; end
        check("wait_done", 64'(cli_done != 3'b000), 1);
    endtask

    task automatic wait_gnt_t();
        int n = 0;
        while (cli_gnt_t == 3'b000 && n < 50) begin @(negedge clk_bus); n++; end
        check("wait_gnt_t", 64'(cli_gnt_t != 3'b000), 1);
    endtask

    task automatic wait_done_t();
        int n = 0;
        while (cli_done_t == 3'b000 && n < 400) begin @(negedge clk_bus); n++; end
        check("wait_done_t", 64'(cli_done_t != 3'b000), 1);
    endtask

    task automatic ack_pulse(input int dly, input int len);
        repeat (dly) @(negedge clk_bus);
        sd_ack = 1'b1;
        repeat (len) @(negedge clk_bus);
        sd_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; cli_req = '0; cli_wr = '0; cli_conf = '0; cli_lba = '0;
        sd_ack = 1'b0; cli_req_t = '0; sd_ack_t = 1'b0;
        repeat (3) @(negedge clk_bus);
        check("rst_gnt", cli_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_sd", {sd_rd, sd_wr, sd_conf, sd_lba}, 0);
        check("rst_done_owner", {cli_done, cli_err, owner}, 0);
        reset_n = 1'b1;
        @(negedge clk_bus);

        // client1 read, ack 5 cycles after grant, high 40 cycles
        cli_lba[32+:32] = 32'h1234;
        cli_req = 3'b010;
        push(1, 32'h1234, 1, 0, 0);
        @(negedge clk_bus);
        check("t1_grant_latency", cli_gnt, 3'b010);
        repeat (4) @(negedge clk_bus);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_bus);
        check("t1_rd_before_sync", sd_rd, 1);
        @(negedge clk_bus);
        check("t1_rd_drop", sd_rd, 0);
        check("t1_busy", busy, 1);
        repeat (37) @(negedge clk_bus);
        sd_ack = 1'b0;
        repeat (2) @(negedge clk_bus);
        check("t1_done_early", cli_done, 0);
        @(negedge clk_bus);
        check("t1_done", cli_done, 3'b010);
        check("t1_err", cli_err, 0);
        cli_req = 3'b000;
        @(negedge clk_bus);
        check("t1_done_once", cli_done, 0);
        check("t1_gnt_clr", cli_gnt, 0);
        check("t1_idle", busy, 0);
        check("t1_lba_hold", sd_lba, 32'h1234);

        // client2 write
        cli_wr[2] = 1'b1;
        cli_lba[64+:32] = 32'hdead_beef;
        cli_req = 3'b100;
        push(2, 32'hdead_beef, 0, 1, 0);
        wait_gnt();
        ack_pulse(2, 5);
        wait_done();
        cli_req = 3'b000;
        @(negedge clk_bus);

        // all three requesting: strict rotation with an idle cycle between grants
        cli_wr = 3'b000;
        cli_lba = {32'h102, 32'h101, 32'h100};
        for (int k = 0; k < 6; k++) push(k % 3, 32'h100 + 32'(k % 3), 1, 0, 0);
        cli_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_gnt();
            check("t3_owner", owner, k % 3);
            ack_pulse(1, 3);
            wait_done();
            if (k == 5) cli_req = 3'b000;
            @(negedge clk_bus);
            check("t3_idle_gap", cli_gnt, 0);
        end

        // client0 config read forces LBA 0
        cli_conf[0] = 1'b1;
        cli_lba[0+:32] = 32'h55;
        cli_req = 3'b001;
        push(0, 32'h0, 1, 0, 1);
        wait_gnt();
        check("t4_conf", sd_conf, 1);
        check("t4_lba_zero", sd_lba, 0);
        ack_pulse(2, 8);
        check("t4_owner_xfer", {busy, owner}, 3'b100);
        wait_done();
        cli_req = 3'b000;
        cli_conf = 3'b000;
        @(negedge clk_bus);
        check("t4_conf_hold", {sd_conf, sd_lba}, {1'b1, 32'h0});

        // client0 drops req during ISSUE while client1 starts requesting
        cli_wr[0] = 1'b1;
        cli_lba[0+:32] = 32'h77;
        cli_req = 3'b001;
        push(0, 32'h77, 0, 1, 0);
        wait_gnt();
        cli_lba[32+:32] = 32'h9abc;
        cli_req = 3'b010;
        push(1, 32'h9abc, 1, 0, 0);
        repeat (3) @(negedge clk_bus);
        check("t5_gnt_held", cli_gnt, 3'b001);
        check("t5_wr_held", sd_wr, 1);
        ack_pulse(1, 4);
        wait_done();
        check("t5_done0", cli_done, 3'b001);
        @(negedge clk_bus);
        check("t5_gap", cli_gnt, 0);
        wait_gnt();
        check("t5_gnt1", cli_gnt, 3'b010);
        ack_pulse(1, 4);
        wait_done();
        cli_req = 3'b000;
        @(negedge clk_bus);

        // async reset during client1 transfer with client2 pending
        cli_req = 3'b010;
        push(1, 32'h9abc, 1, 0, 0);
        wait_gnt();
        cli_lba[64+:32] = 32'h2222;
        cli_wr[2] = 1'b0;
        cli_req = 3'b110;
        sd_ack = 1'b1;
        repeat (4) @(negedge clk_bus);
        check("t6_in_xfer", {sd_rd, busy, cli_gnt}, 5'b01010);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_gnt", cli_gnt, 0);
        check("t6_rst_sd", {sd_rd, sd_wr, sd_conf, sd_lba}, 0);
        check("t6_rst_misc", {cli_done, cli_err, owner, busy}, 0);
        sd_ack = 1'b0;
        cli_req = 3'b100;
        sb.delete();
        push(2, 32'h2222, 1, 0, 0);
        @(negedge clk_bus);
        check("t6_no_done", cli_done, 0);
        @(negedge clk_bus);
        reset_n = 1'b1;
        wait_gnt();
        check("t6_gnt2", cli_gnt, 3'b100);
        ack_pulse(1, 3);
        wait_done();
        cli_req = 3'b000;
        @(negedge clk_bus);

        // TMO_W=4 instance: client2 write with no ack aborts after 15 cycles
        cli_wr[2] = 1'b1;
        cli_conf = 3'b000;
        cli_req_t = 3'b100;
        wait_gnt_t();
        check("t7_wr_set", sd_wr_t, 1);
        repeat (14) @(negedge clk_bus);
        check("t7_wr_before_tmo", {sd_wr_t, cli_done_t}, 4'b1000);
        @(negedge clk_bus);
        check("t7_wr_drop", sd_wr_t, 0);
        check("t7_done", cli_done_t, 3'b100);
        check("t7_err", cli_err_t, 1);
        cli_req_t = 3'b000;
        @(negedge clk_bus);
        check("t7_idle", {busy_t, cli_gnt_t, cli_done_t}, 0);

        // TMO_W=4 instance: timeout while ack stuck high holds done until ack drops
        cli_wr[0] = 1'b0;
        cli_req_t = 3'b001;
        wait_gnt_t();
        repeat (2) @(negedge clk_bus);
        sd_ack_t = 1'b1;
        repeat (20) @(negedge clk_bus);
        check("t8_hold_no_done", cli_done_t, 0);
        check("t8_hold_busy", {busy_t, sd_rd_t, cli_gnt_t}, 5'b10001);
        sd_ack_t = 1'b0;
        wait_done_t();
        check("t8_done", cli_done_t, 3'b001);
        check("t8_err", cli_err_t, 1);
        cli_req_t = 3'b000;
        @(negedge clk_bus);
        check("t8_done_once", {busy_t, cli_done_t}, 0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
